// File: rtl/mem_dma.sv
// mem_dma: single-channel word copy engine on a valid/ready memory port.
// One request is outstanding at a time; each word is a read followed by a
// write. Optional fill mode (define MEM_DMA_FILL_EN) writes a constant
// pattern instead of copying and skips the read half of every word.

package mem_pkg;

    localparam int unsigned MEM_ADDR_W = 12;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_MASK_W = MEM_DATA_W / 8;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_type_t;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] req_addr;
        logic [MEM_DATA_W-1:0] req_data;
        logic [MEM_MASK_W-1:0] req_mask;
        mem_type_t             req_type;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] resp_data;
    } mem_resp_t;

endpackage

module mem_dma
    import mem_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [MEM_ADDR_W-1:0] src_addr,
    input  logic [MEM_ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]      len_words,
`ifdef MEM_DMA_FILL_EN
    input  logic                  fill,
    input  logic [MEM_DATA_W-1:0] fill_data,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output mem_req_t              mem_req,
    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready,
    input  mem_resp_t             mem_resp
);

    localparam logic [MEM_ADDR_W-1:0] WORD_MASK = ~MEM_ADDR_W'(3);
    localparam logic [MEM_ADDR_W-1:0] WORD_STEP = MEM_ADDR_W'(4);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_RESP = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                state;
    logic [MEM_ADDR_W-1:0] src_q;
    logic [MEM_ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]      cnt_q;
    logic [MEM_DATA_W-1:0] data_q;

    // Fill-mode controls; tied off in the copy-only build.
    logic                  fill_mode;
    logic                  req_fill;
    logic [MEM_DATA_W-1:0] req_fill_data;

`ifdef MEM_DMA_FILL_EN
    logic fill_q;

    assign fill_mode     = fill_q;
    assign req_fill      = fill;
    assign req_fill_data = fill_data;

    // Remember the transfer mode for the whole job.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fill_q <= 1'b0;
        end else if (state == IDLE && start) begin
            fill_q <= fill;
        end
    end
`else
    assign fill_mode     = 1'b0;
    assign req_fill      = 1'b0;
    assign req_fill_data = '0;
`endif

    // Read request payload; data and mask are zero for reads.
    function automatic mem_req_t rd_req(input logic [MEM_ADDR_W-1:0] addr);
        mem_req_t r;
        r          = '0;
        r.req_addr = addr;
        r.req_type = MEM_READ;
        return r;
    endfunction

    // Full-word write request payload.
    function automatic mem_req_t wr_req(input logic [MEM_ADDR_W-1:0] addr,
                                        input logic [MEM_DATA_W-1:0] data);
        mem_req_t r;
        r          = '0;
        r.req_addr = addr;
        r.req_data = data;
        r.req_mask = '1;
        r.req_type = MEM_WRITE;
        return r;
    endfunction

    // Transfer FSM with registered handshake, status and payload outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= IDLE;
            src_q          <= '0;
            dst_q          <= '0;
            cnt_q          <= '0;
            data_q         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_req_valid  <= 1'b0;
            mem_resp_ready <= 1'b0;
            mem_req        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q  <= src_addr & WORD_MASK;
                        dst_q  <= dst_addr & WORD_MASK;
                        cnt_q  <= len_words;
                        data_q <= req_fill_data;
                        if (len_words == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (req_fill) begin
                            state         <= WR_REQ;
                            busy          <= 1'b1;
                            mem_req_valid <= 1'b1;
                            mem_req       <= wr_req(dst_addr & WORD_MASK, req_fill_data);
                        end else begin
                            state         <= RD_REQ;
                            busy          <= 1'b1;
                            mem_req_valid <= 1'b1;
                            mem_req       <= rd_req(src_addr & WORD_MASK);
                        end
                    end
                end

                RD_REQ: begin
                    if (mem_req_ready) begin
                        state          <= RD_RESP;
                        mem_req_valid  <= 1'b0;
                        mem_req        <= '0;
                        mem_resp_ready <= 1'b1;
                    end else begin
                        mem_req <= rd_req(src_q);
                    end
                end

                RD_RESP: begin
                    if (mem_resp_valid) begin
                        state          <= WR_REQ;
                        data_q         <= mem_resp.resp_data;
                        mem_resp_ready <= 1'b0;
                        mem_req_valid  <= 1'b1;
                        mem_req        <= wr_req(dst_q, mem_resp.resp_data);
                    end
                end

                WR_REQ: begin
                    if (mem_req_ready) begin
                        state          <= WR_RESP;
                        mem_req_valid  <= 1'b0;
                        mem_req        <= '0;
                        mem_resp_ready <= 1'b1;
                    end else begin
                        mem_req <= wr_req(dst_q, data_q);
                    end
                end

                WR_RESP: begin
                    if (mem_resp_valid) begin
                        src_q          <= src_q + WORD_STEP;
                        dst_q          <= dst_q + WORD_STEP;
                        cnt_q          <= cnt_q - LEN_W'(1);
                        mem_resp_ready <= 1'b0;
                        if (cnt_q == LEN_W'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (fill_mode) begin
                            state         <= WR_REQ;
                            mem_req_valid <= 1'b1;
                            mem_req       <= wr_req(dst_q + WORD_STEP, data_q);
                        end else begin
                            state         <= RD_REQ;
                            mem_req_valid <= 1'b1;
                            mem_req       <= rd_req(src_q + WORD_STEP);
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
